// File: rtl/laser_pkg.sv
// Shared constants and FSM encoding for the frame block-scan scheduler.
package laser_pkg;

  localparam int LOADER_LATENCY = 19;
  localparam int BLOCKS_X_DEF   = 160;
  localparam int BLOCKS_Y_DEF   = 120;
  localparam int COORD_W_DEF    = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_ADVANCE = 3'd4,
    S_PAUSE   = 3'd5
  } state_e;

endpackage

// File: rtl/block_scan_scheduler_coord.sv
// Raster x/y block counter: steps column-first, wraps to (0,0) after the last block.
module block_coord_counter
  import laser_pkg::*;
#(
  parameter int BLOCKS_X = BLOCKS_X_DEF,
  parameter int BLOCKS_Y = BLOCKS_Y_DEF,
  parameter int COORD_W  = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               advance_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(BLOCKS_X - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(BLOCKS_Y - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q < X_LAST) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        y_d = (y_q < Y_LAST) ? y_q + 1'b1 : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/block_scan_scheduler.sv
// Walks the 4x4 block loader over a frame and hands each loaded block downstream.
module block_scan_scheduler
  import laser_pkg::*;
#(
  parameter int BLOCKS_X = BLOCKS_X_DEF,
  parameter int BLOCKS_Y = BLOCKS_Y_DEF,
  parameter int TIMEOUT  = 64,
  parameter int COORD_W  = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               continuous,
  input  logic               enable,
  output logic               loader_start,
  output logic [COORD_W-1:0] block_x,
  output logic [COORD_W-1:0] block_y,
  input  logic               loader_done,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Trip when the watchdog steps onto TIMEOUT-1, so the error lands TIMEOUT cycles after start.
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT - 2);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            cnt_clear, cnt_adv, last_blk;

  block_coord_counter #(
    .BLOCKS_X(BLOCKS_X),
    .BLOCKS_Y(BLOCKS_Y),
    .COORD_W (COORD_W)
  ) u_coord (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (cnt_clear),
    .advance_i(cnt_adv),
    .x_o      (block_x),
    .y_o      (block_y),
    .last_o   (last_blk)
  );

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    err_d     = err_q;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_clear = 1'b1;
        if (frame_start && enable) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        if (loader_done) begin
          state_d = S_PRESENT;
        end else if (wd_q == WD_TRIP) begin
          err_d     = 1'b1;
          cnt_clear = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_PRESENT: begin
        if (blk_ready) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        // Counter wraps to (0,0) on the last block, so advance alone handles frame end.
        cnt_adv = 1'b1;
        if (last_blk) state_d = (continuous && enable) ? S_ISSUE : S_IDLE;
        else          state_d = enable ? S_ISSUE : S_PAUSE;
      end
      S_PAUSE: begin
        if (enable) state_d = S_ISSUE;
      end
      default: begin
        cnt_clear = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign loader_start = (state_q == S_ISSUE);
  assign blk_valid    = (state_q == S_PRESENT);
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_ADVANCE) && last_blk;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_block_scan_scheduler.sv
// Scoreboard bench: stimulus queues expected starts/acceptances/frame ends, a monitor checks them.
module tb_block_scan_scheduler;
  import laser_pkg::*;

  localparam int BX = 3;
  localparam int BY = 2;
  localparam int TO = 64;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frame_start = 1'b0, continuous = 1'b0, enable = 1'b1;
  logic       loader_done = 1'b0, blk_ready = 1'b1;
  logic       loader_start, blk_valid, busy, frame_done, timeout_err;
  logic [7:0] block_x, block_y;

  int checks = 0;
  int errors = 0;

  typedef struct {int x; int y;} coord_t;
  coord_t start_q[$];
  coord_t acc_q[$];
  int     fd_q = 0;
  bit     hang = 1'b0;
  int     ld_cnt = 0;

  always #5 clk = ~clk;

  block_scan_scheduler #(.BLOCKS_X(BX), .BLOCKS_Y(BY), .TIMEOUT(TO), .COORD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .continuous(continuous),
    .enable(enable), .loader_start(loader_start), .block_x(block_x), .block_y(block_y),
    .loader_done(loader_done), .blk_valid(blk_valid), .blk_ready(blk_ready), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_blocks(input int from, input int to, input bit with_acc);
    coord_t c;
    for (int i = from; i <= to; i++) begin
      c.x = i % BX;
      c.y = i / BX;
      start_q.push_back(c);
      if (with_acc) acc_q.push_back(c);
    end
  endtask

  task automatic push_frame();
    push_blocks(0, BX * BY - 1, 1'b1);
    fd_q++;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk(name, busy, 0);
  endtask

  task automatic wait_start(input int x, input int y, input int budget, input string name);
    int n = 0;
    while (!(loader_start && block_x == 8'(x) && block_y == 8'(y)) && n < budget) begin
      tick(); n++;
    end
    chk(name, loader_start, 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!blk_valid && n < budget) begin tick(); n++; end
    chk(name, blk_valid, 1);
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_starts_left"}, start_q.size(), 0);
    chk({name, "_accepts_left"}, acc_q.size(), 0);
    chk({name, "_frames_left"}, fd_q, 0);
  endtask

  // Loader model: done pulses LOADER_LATENCY cycles after the start cycle; not cancelled by reset.
  initial begin
    forever begin
      tick();
      loader_done = 1'b0;
      if (ld_cnt > 0) begin
        ld_cnt--;
        if (ld_cnt == 0 && !hang) loader_done = 1'b1;
      end
      if (loader_start) ld_cnt = LOADER_LATENCY;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start, an accept or a frame end.
  initial begin
    bit     prev_s, prev_v, prev_r;
    coord_t c;
    prev_s = 1'b0; prev_v = 1'b0; prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_s = 1'b0; prev_v = 1'b0; prev_r = 1'b0;
        continue;
      end
      if (loader_start) begin
        chk("start_single_cycle", prev_s, 0);
        chk("start_expected", start_q.size() > 0, 1);
        if (start_q.size() > 0) begin
          c = start_q.pop_front();
          chk("start_x", block_x, c.x);
          chk("start_y", block_y, c.y);
        end
      end
      if (prev_v && !prev_r) chk("valid_held_without_ready", blk_valid, 1);
      if (blk_valid && blk_ready) begin
        chk("accept_expected", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          c = acc_q.pop_front();
          chk("accept_x", block_x, c.x);
          chk("accept_y", block_y, c.y);
        end
      end
      if (frame_done) begin
        chk("frame_done_expected", fd_q > 0, 1);
        if (fd_q > 0) fd_q--;
      end
      prev_s = loader_start; prev_v = blk_valid; prev_r = blk_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", loader_start, 0);
    chk("rst_valid", blk_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_x", block_x, 0);
    chk("rst_y", block_y, 0);

    // Plain frame, ready tied high
    push_frame();
    pulse_start();
    chk("t1_busy_after_start", busy, 1);
    wait_idle(400, "t1_idle");
    chk("t1_x_end", block_x, 0);
    chk("t1_y_end", block_y, 0);
    chk_empty("t1");

    // Consumer stalls block (1,0) for 5 cycles
    push_frame();
    pulse_start();
    wait_start(1, 0, 200, "t2_start_1_0");
    blk_ready = 1'b0;
    wait_valid(100, "t2_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid_stall", blk_valid, 1);
      chk("t2_x_stall", block_x, 1);
      chk("t2_no_start_stall", loader_start, 0);
    end
    blk_ready = 1'b1;
    wait_idle(400, "t2_idle");
    chk_empty("t2");

    // enable dropped mid-load: block finishes, scheduler parks on (1,0)
    push_blocks(0, 0, 1'b1);
    pulse_start();
    tick(); tick();
    enable = 1'b0;
    wait_valid(100, "t3_valid");
    tick();
    tick();
    chk("t3_pause_busy", busy, 1);
    chk("t3_pause_x", block_x, 1);
    chk("t3_pause_y", block_y, 0);
    chk("t3_pause_valid", blk_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_pause_no_start", loader_start, 0);
    end
    push_blocks(1, BX * BY - 1, 1'b1);
    fd_q++;
    enable = 1'b1;
    tick();
    chk("t3_resume_start", loader_start, 1);
    chk("t3_resume_x", block_x, 1);
    wait_idle(400, "t3_idle");
    chk_empty("t3");

    // Hung loader: watchdog fires TIMEOUT cycles after the start cycle
    hang = 1'b1;
    push_blocks(0, 0, 1'b0);
    pulse_start();
    n = 0;
    while (!timeout_err && n < 200) begin tick(); n++; end
    chk("t4_timeout_latency", n, TO);
    chk("t4_busy", busy, 0);
    chk("t4_x", block_x, 0);
    chk("t4_y", block_y, 0);
    hang = 1'b0;
    push_frame();
    pulse_start();
    wait_idle(400, "t4_idle");
    chk("t4_err_sticky", timeout_err, 1);
    chk_empty("t4");

    // Continuous re-scan; frame_start noise mid-frame is ignored
    continuous = 1'b1;
    push_frame();
    push_frame();
    pulse_start();
    repeat (10) tick();
    frame_start = 1'b1;
    repeat (3) tick();
    frame_start = 1'b0;
    n = 0;
    while (!frame_done && n < 300) begin tick(); n++; end
    chk("t5_frame_done", frame_done, 1);
    tick();
    chk("t5_restart", loader_start, 1);
    chk("t5_restart_x", block_x, 0);
    chk("t5_restart_y", block_y, 0);
    continuous = 1'b0;
    repeat (30) tick();
    pulse_start();
    wait_idle(400, "t5_idle");
    chk_empty("t5");

    // Async reset while loading (2,0); the late loader done must be ignored
    push_blocks(0, 2, 1'b0);
    acc_q.push_back('{x: 0, y: 0});
    acc_q.push_back('{x: 1, y: 0});
    pulse_start();
    wait_start(2, 0, 200, "t6_start_2_0");
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_start", loader_start, 0);
    chk("t6_rst_valid", blk_valid, 0);
    chk("t6_rst_x", block_x, 0);
    chk("t6_rst_err", timeout_err, 0);
    chk("t6_rst_frame_done", frame_done, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t6_late_done_ignored", busy, 0);
    chk_empty("t6_pre");
    push_frame();
    pulse_start();
    wait_idle(400, "t6_idle");
    chk_empty("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_scan_scheduler.md
Name: block_scan_scheduler

Overview:
- Sequences the 4x4 pixel-block loader across a full frame, raster order: block (0,0) through (BLOCKS_X-1, BLOCKS_Y-1).
- For each block: drives the loader's block coordinates, issues a one-cycle start, waits for its done pulse, then presents the loaded block to the downstream laser path-planning stage with a valid/ready handshake.
- Sits between the frame-buffer read side (loader) and the projector point generator.
- Provides per-frame done, continuous re-scan and a loader-hang watchdog.

Parameters:
- BLOCKS_X, 160, blocks per row (640/4).
- BLOCKS_Y, 120, block rows per frame (480/4).
- TIMEOUT, 64, max cycles from start pulse to loader done; must be > 19.
- COORD_W, 8, width of block coordinates (matches loader block_x/block_y).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  begin a frame scan (level sampled in IDLE).
- continuous  in  1  when 1, a new scan auto-starts after frame end.
- enable  in  1  0 = pause at next block boundary.
- loader_start  out  1  one-cycle start pulse to loader.
- block_x  out  COORD_W  current block column to loader/consumer.
- block_y  out  COORD_W  current block row to loader/consumer.
- loader_done  in  1  loader completion pulse.
- blk_valid  out  1  loaded block's pixels are stable for consumer.
- blk_ready  in  1  consumer accepts block.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after last block accepted.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE; block_x=block_y=0; loader_start=0; blk_valid=0; busy=0; frame_done=0; timeout_err=0; watchdog=0.
- States: IDLE, ISSUE, WAIT, PRESENT, ADVANCE, PAUSE.
- IDLE: block_x/y held 0. If frame_start=1 and enable=1, go ISSUE next cycle.
- ISSUE: loader_start=1 for exactly this cycle; watchdog cleared; go WAIT. start must never be high for 2 cycles, or the loader restarts.
- WAIT:
  - watchdog increments each cycle.
  - loader_done=1: go PRESENT.
  - watchdog reaches TIMEOUT-1 without done: timeout_err<=1, go IDLE, no frame_done.
  - Nominal loader latency: done high 19 cycles after the start cycle.
- PRESENT: blk_valid=1; block_x/y stable. On blk_valid&blk_ready, go ADVANCE; blk_valid drops the following cycle. Valid never retracts without ready.
- ADVANCE (1 cycle):
  - If block_x<BLOCKS_X-1: block_x+1.
  - Else block_x=0 and, if block_y<BLOCKS_Y-1, block_y+1.
  - Otherwise (last block): frame_done pulses this cycle, block_x/y<=0; next state ISSUE if continuous&enable, else IDLE.
  - Non-last block: next ISSUE if enable=1, else PAUSE.
- PAUSE: coordinates held; go ISSUE when enable=1.
- block_x/y change only in ADVANCE, reset, or timeout exit. They are constant from ISSUE through PRESENT, which the loader requires because its address is combinational in them.
- enable=0 never aborts an in-flight load or presentation; it only takes effect at ADVANCE.
- frame_start outside IDLE is ignored (no queuing).
- timeout_err clears only on reset. A new frame_start after a timeout is still honoured.
- Spurious loader_done outside WAIT is ignored.
- Reset mid-load: scheduler returns to IDLE immediately. The loader finishes its own sequence, and its done lands in IDLE, where it is ignored.
- Counters are COORD_W bits and never wrap past BLOCKS_X-1/BLOCKS_Y-1. Watchdog is clog2(TIMEOUT) bits, saturating.

Decomposition:
- Shared package laser_pkg: state encoding constants, LOADER_LATENCY=19, default BLOCKS_X/BLOCKS_Y, COORD_W.
- One natural sub-module: block_coord_counter. It holds the x/y raster counter with advance/clear inputs and a last_block output; the FSM stays in the top.

Test Plan:
- BLOCKS_X=3, BLOCKS_Y=2, loader model with 19-cycle done, blk_ready tied 1, frame_start pulse -> 6 loader_start pulses with coords (0,0)(1,0)(2,0)(0,1)(1,1)(2,1), frame_done one pulse, back to IDLE with busy=0.
- Same, blk_ready low 5 cycles on block (1,0) -> blk_valid held 5+ cycles, block_x=1 stable, no start issued until handshake completes.
- enable dropped while in WAIT on (0,0) -> block (0,0) completes and is presented, state PAUSE with coords (1,0); enable=1 -> ISSUE for (1,0).
- Loader model never asserts done -> timeout_err=1 after TIMEOUT cycles, state IDLE, coords (0,0), frame_done never asserted; next frame_start runs normally with timeout_err still 1.
- continuous=1 -> after frame_done, next cycle loader_start for (0,0) with no frame_start; frame_start pulses mid-frame do not disturb the sequence.
- rst_n asserted during WAIT on (2,0) -> all outputs 0 immediately (async), late loader_done ignored, frame_start then scans from (0,0).
